// File: rtl/pois_sched.sv
`default_nettype none
// ============================================================================
// Module   : pois_sched
// Purpose  : Round-robin scheduler that shares one Poisson sampler among NREQ
//            requesters. It issues uniform random words to the sampler with a
//            requester tag, re-associates each sampler result with its tag, and
//            delivers {tag, result} through a credit-protected output FIFO.
// Ports    : CLK, RESET_N (async, active low)
//            REQ/GNT              requester handshake (GNT one-hot, combinational)
//            RAND_VALID/RAND/ACK  uniform random word source
//            S_VALID/S_RAND       to sampler; S_RESULT from sampler
//            OUT_VALID/READY/ID/RESULT  result stream with backpressure
//            STAT_CNT             pop counter (only with POIS_SCHED_STATS_EN)
// Options  : `define POIS_SCHED_STATS_EN adds the 32-bit STAT_CNT output.
// Revision : 1.0 - initial release
// ============================================================================
module pois_sched #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int SLAT  = 1,
  parameter int DEPTH = 4,
  parameter int DELAY = 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NREQ-1:0]   REQ,
  output logic [NREQ-1:0]   GNT,
  input  logic              RAND_VALID,
  input  logic [27:0]       RAND,
  output logic              RAND_ACK,
  output logic              S_VALID,
  output logic [27:0]       S_RAND,
  input  logic [3:0]        S_RESULT,
`ifdef POIS_SCHED_STATS_EN
  output logic [31:0]       STAT_CNT,
`endif
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [IDW-1:0]    OUT_ID,
  output logic [3:0]        OUT_RESULT
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;   // FIFO pointer width (extra wrap bit)
  localparam int CW = PW + 1;   // width of inflight + occupancy sum

  // DELAY only models register delay in behavioural sims of the original
  // block; it has no meaning in synthesizable logic and is intentionally inert.
  generate
    if (DELAY < 0) begin : g_delay_unused
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [IDW-1:0]             ptr_q, ptr_d;
  logic                       s_valid_q, s_valid_d;
  logic [27:0]                s_rand_q, s_rand_d;
  logic [IDW-1:0]             s_tag_q, s_tag_d;
  logic [SLAT-1:0]            vld_pipe_q, vld_pipe_d;
  logic [SLAT-1:0][IDW-1:0]   tag_pipe_q, tag_pipe_d;
  logic [PW-1:0]              inflight_q, inflight_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][IDW+3:0]  fifo_mem_q;

  // --------------------------------------------------------------------------
  // Combinational
  // --------------------------------------------------------------------------
  logic [IDW-1:0] win_idx;
  logic           win_found;
  logic           issue;
  logic           credit_ok;
  logic           push;
  logic           pop;
  logic           fifo_empty;
  logic [PW-1:0]  occupancy;
  logic [IDW+3:0] head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign occupancy  = wr_ptr_q - rd_ptr_q;
  // inflight + occupancy equals issued-but-not-popped; bounding it by DEPTH
  // guarantees every sampler result finds a free FIFO slot.
  assign credit_ok  = (CW'(inflight_q) + CW'(occupancy)) < CW'(DEPTH);
  assign push       = vld_pipe_q[SLAT-1];
  assign pop        = !fifo_empty && OUT_READY;
  assign head       = fifo_mem_q[rd_ptr_q[AW-1:0]];

  // Round-robin search starting one past the last winner.
  always_comb begin
    int unsigned cand;
    win_idx   = '0;
    win_found = 1'b0;
    cand      = 0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = (int'(ptr_q) + i) % NREQ;
      if (!win_found && REQ[cand]) begin
        win_found = 1'b1;
        win_idx   = IDW'(cand);
      end
    end
  end

  always_comb begin
    // RESET_N gates issue so no grant is visible while reset is held.
    issue = RESET_N && RAND_VALID && win_found && credit_ok;
    GNT   = '0;
    if (issue) GNT[win_idx] = 1'b1;

    ptr_d     = issue ? win_idx : ptr_q;
    s_valid_d = issue;
    s_rand_d  = issue ? RAND : s_rand_q;
    s_tag_d   = issue ? win_idx : s_tag_q;

    // Tag pipeline: stage k lines up with the sampler output k+1 cycles
    // after S_VALID, so the last stage is aligned with S_RESULT.
    vld_pipe_d    = '0;
    tag_pipe_d    = '0;
    vld_pipe_d[0] = s_valid_q;
    tag_pipe_d[0] = s_tag_q;
    for (int i = 1; i < SLAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      tag_pipe_d[i] = tag_pipe_q[i-1];
    end

    inflight_d = inflight_q;
    if (issue && !push)      inflight_d = inflight_q + PW'(1);
    else if (!issue && push) inflight_d = inflight_q - PW'(1);

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
  end

  assign RAND_ACK   = |GNT;
  assign S_VALID    = s_valid_q;
  assign S_RAND     = s_rand_q;
  assign OUT_VALID  = !fifo_empty;
  // Head fields read as zero while empty so reset leaves the outputs at 0.
  assign OUT_ID     = fifo_empty ? '0 : head[IDW+3:4];
  assign OUT_RESULT = fifo_empty ? '0 : head[3:0];

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ptr_q      <= IDW'(NREQ - 1);
      s_valid_q  <= 1'b0;
      s_rand_q   <= '0;
      s_tag_q    <= '0;
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s_valid_q  <= s_valid_d;
      s_rand_q   <= s_rand_d;
      s_tag_q    <= s_tag_d;
      vld_pipe_q <= vld_pipe_d;
      tag_pipe_q <= tag_pipe_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: pointers define which entries are meaningful.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= {tag_pipe_q[SLAT-1], S_RESULT};
  end

`ifdef POIS_SCHED_STATS_EN
  logic [31:0] stat_cnt_q, stat_cnt_d;

  always_comb begin
    stat_cnt_d = stat_cnt_q + 32'(pop);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) stat_cnt_q <= '0;
    else          stat_cnt_q <= stat_cnt_d;
  end

  assign STAT_CNT = stat_cnt_q;
`endif

endmodule
`default_nettype wire
